// File: rtl/mem_pkg.sv
// Shared constants and types for the matrix-engine storage complex:
// data-bus geometry, instruction geometry and the instruction-unpacking helper.
package mem_pkg;

  // Data bus geometry.
  localparam int DATA_W         = 256;
  localparam int ADDR_W         = 3;

  // Instruction store geometry.
  localparam int INST_W         = 12;
  localparam int INST_DEPTH     = 32;
  localparam int INST_ADDR_W    = 5;
  localparam int INSTS_PER_WORD = 21;

  // Bits of one bus word that carry instructions (the low nibble is unused).
  localparam int LOAD_W         = INSTS_PER_WORD * INST_W;

  // Number of RAM words; the RAM owns every slot below RESULT_ADDR.
  localparam int RAM_WORDS      = 7;

  typedef logic [DATA_W-1:0]      word_t;
  typedef logic [INST_W-1:0]      inst_t;
  typedef logic [ADDR_W-1:0]      bus_addr_t;
  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [LOAD_W-1:0]      load_word_t;

  // Bus slot owned by the result register.
  localparam bus_addr_t RESULT_ADDR = 3'd7;

  // Instruction idx of a bulk-load word; entry 0 is the most significant slice.
  function automatic inst_t inst_slice(input load_word_t w, input int idx);
    return w[(INSTS_PER_WORD - 1 - idx) * INST_W +: INST_W];
  endfunction

endpackage

// File: rtl/memory_subsystem_if.sv
// Control side of the storage complex: bus slot select, enable and direction,
// the instruction bulk-load strobe and the program-counter read port.
// The 256-bit data bus itself is a separate tri-state port on the top level.
interface memory_subsystem_if;

  mem_pkg::bus_addr_t  address_select;
  logic                nEnable;
  logic                ReadWrite;
  logic                load_instrs;
  mem_pkg::inst_addr_t inst_address;
  mem_pkg::inst_t      inst_read;

  // Bus controller / program counter side.
  modport master (
    output address_select,
    output nEnable,
    output ReadWrite,
    output load_instrs,
    output inst_address,
    input  inst_read
  );

  // Storage complex side.
  modport slave (
    input  address_select,
    input  nEnable,
    input  ReadWrite,
    input  load_instrs,
    input  inst_address,
    output inst_read
  );

endinterface

// File: rtl/instruction_memory.sv
// 32-entry instruction store. A bulk load unpacks the instruction-carrying
// bits of one bus word into entries 0..20 and zeroes the rest; the program
// counter reads any entry combinationally.
module instruction_memory
  import mem_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  load_word_t i_bus,
  input  logic       i_load,
  input  inst_addr_t i_addr,
  output inst_t      o_inst
);

  inst_t r_inst [INST_DEPTH];

  // Storage: clear on reset; a load rewrites every entry from the pre-edge bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < INST_DEPTH; i++) begin
        r_inst[i] <= '0;
      end
    end else if (i_load) begin
      for (int i = 0; i < INSTS_PER_WORD; i++) begin
        r_inst[i] <= inst_slice(i_bus, i);
      end
      for (int i = INSTS_PER_WORD; i < INST_DEPTH; i++) begin
        r_inst[i] <= '0;
      end
    end
  end

  // All 32 addresses are populated, so the read needs no range guard.
  assign o_inst = r_inst[i_addr];

endmodule

// File: rtl/memory.sv
// Seven-word main RAM on the shared data bus. Owns every slot except
// RESULT_ADDR, decodes its own accesses and drives the bus only while the
// selected slot is one of its own and a read is enabled.
module memory
  import mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  inout  wire  [DATA_W-1:0] io_data_bus,
  input  bus_addr_t         i_addr,
  input  logic              i_n_en,
  input  logic              i_rd_wr
);

  word_t r_mem [RAM_WORDS];

  logic  w_sel;
  logic  w_wr;
  logic  w_rd;
  word_t w_rdata;

  // Slot decode: every slot below the result register belongs to the RAM.
  assign w_sel = (i_addr != RESULT_ADDR);
  assign w_wr  = w_sel && !i_n_en && !i_rd_wr;
  assign w_rd  = w_sel && !i_n_en &&  i_rd_wr;

  // Storage: clear every word on reset, capture the bus on a RAM write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RAM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[i_addr] <= io_data_bus;
    end
  end

  // Read mux: only index the array for slots the RAM actually owns.
  always_comb begin
    w_rdata = '0;
    if (w_sel) begin
      w_rdata = r_mem[i_addr];
    end else begin
      w_rdata = '0;
    end
  end

  // The driver releases in the same combinational path as the enables.
  assign io_data_bus = w_rd ? w_rdata : {DATA_W{1'bz}};

endmodule

// File: rtl/result_reg.sv
// Single-word result register on the shared data bus at slot RESULT_ADDR.
// Decodes its own slot and drives the bus only on an enabled read of it.
module result_reg
  import mem_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  inout  wire  [DATA_W-1:0] io_data_bus,
  input  bus_addr_t         i_addr,
  input  logic              i_n_en,
  input  logic              i_rd_wr
);

  word_t r_result;

  logic  w_sel;
  logic  w_wr;
  logic  w_rd;

  // Slot decode for the single slot this unit owns.
  assign w_sel = (i_addr == RESULT_ADDR);
  assign w_wr  = w_sel && !i_n_en && !i_rd_wr;
  assign w_rd  = w_sel && !i_n_en &&  i_rd_wr;

  // Storage: clear on reset, capture the bus on a write to the result slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= '0;
    end else if (w_wr) begin
      r_result <= io_data_bus;
    end
  end

  // Tri-state driver: released whenever this slot is not being read.
  assign io_data_bus = w_rd ? r_result : {DATA_W{1'bz}};

endmodule

// File: rtl/memory_subsystem.sv
// Storage complex of the 16-bit RISC matrix engine: main RAM and result
// register sharing a tri-state 256-bit data bus, plus the instruction store
// that is bulk-loaded from that same bus.
module memory_subsystem
  import mem_pkg::*;
(
  input  logic                clk,
  input  logic                Reset,
  inout  wire  [DATA_W-1:0]   dataBus,
  memory_subsystem_if.slave   bus
);

  // Instruction-carrying part of the bus; the low nibble never reaches the store.
  load_word_t w_load_word;

  assign w_load_word = dataBus[DATA_W-1 -: LOAD_W];

  memory u_memory (
    .i_clk       (clk),
    .i_rst_n     (Reset),
    .io_data_bus (dataBus),
    .i_addr      (bus.address_select),
    .i_n_en      (bus.nEnable),
    .i_rd_wr     (bus.ReadWrite)
  );

  result_reg u_result_reg (
    .i_clk       (clk),
    .i_rst_n     (Reset),
    .io_data_bus (dataBus),
    .i_addr      (bus.address_select),
    .i_n_en      (bus.nEnable),
    .i_rd_wr     (bus.ReadWrite)
  );

  instruction_memory u_instruction_memory (
    .i_clk   (clk),
    .i_rst_n (Reset),
    .i_bus   (w_load_word),
    .i_load  (bus.load_instrs),
    .i_addr  (bus.inst_address),
    .o_inst  (bus.inst_read)
  );

endmodule

// File: tb/tb_memory_subsystem.sv
// Directed bench for memory_subsystem: reset, RAM and result-register access,
// instruction bulk load, bus release, back-to-back access, and reset priority.
module tb_memory_subsystem;

  logic         clk;
  logic         reset_n;
  wire  [255:0] data_bus;
  logic [255:0] tb_drv;
  logic         tb_drv_en;

  int err_cnt;
  int chk_cnt;

  localparam logic [255:0] INST_WORD =
    256'hF0D301AAA00F0002000D0008000200090009000B0006000700220004000C0004;
  localparam logic [255:0] EXT_PAT =
    256'hA5A5_5A5A_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_C3C3_3C3C_9999_6666_1111_0055;
  localparam logic [255:0] SIM_WORD = {12'h5A5, 12'h0F1, 228'd0, 4'hF};

  memory_subsystem_if bus_if ();

  assign data_bus = tb_drv_en ? tb_drv : {256{1'bz}};

  memory_subsystem dut (
    .clk     (clk),
    .Reset   (reset_n),
    .dataBus (data_bus),
    .bus     (bus_if)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic go_idle();
    bus_if.nEnable     = 1'b1;
    bus_if.ReadWrite   = 1'b1;
    bus_if.load_instrs = 1'b0;
    tb_drv_en          = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [255:0] data);
    @(negedge clk);
    bus_if.address_select = addr;
    bus_if.nEnable        = 1'b0;
    bus_if.ReadWrite      = 1'b0;
    tb_drv                = data;
    tb_drv_en             = 1'b1;
    @(posedge clk);
    #1;
    go_idle();
  endtask

  task automatic bus_read_check(input string tag, input logic [2:0] addr, input logic [255:0] exp);
    @(negedge clk);
    tb_drv_en             = 1'b0;
    bus_if.address_select = addr;
    bus_if.nEnable        = 1'b0;
    bus_if.ReadWrite      = 1'b1;
    #1;
    check_eq(tag, data_bus, exp);
    go_idle();
  endtask

  task automatic inst_check(input string tag, input logic [4:0] addr, input logic [11:0] exp);
    bus_if.inst_address = addr;
    #1;
    check_eq(tag, {244'd0, bus_if.inst_read}, {244'd0, exp});
  endtask

  // External driver with the block expected to be released (no clock edge).
  task automatic release_check(input string tag, input logic [2:0] addr, input logic n_en, input logic rw);
    @(negedge clk);
    bus_if.address_select = addr;
    bus_if.nEnable        = n_en;
    bus_if.ReadWrite      = rw;
    tb_drv                = EXT_PAT;
    tb_drv_en             = 1'b1;
    #1;
    check_eq(tag, data_bus, EXT_PAT);
    #1;
    go_idle();
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    tb_drv  = '0;
    bus_if.address_select = 3'd0;
    bus_if.inst_address   = 5'd0;
    go_idle();
    reset_n = 1'b0;

    // Reset state.
    #12;
    inst_check("rst_inst0", 5'd0, 12'h000);
    bus_read_check("rst_slot0", 3'd0, 256'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // RAM write/read.
    bus_write(3'd0, 256'd42);
    bus_write(3'd1, 256'd56);
    bus_write(3'd5, 256'd5);
    bus_read_check("ram_slot0", 3'd0, 256'd42);
    bus_read_check("ram_slot1", 3'd1, 256'd56);
    bus_read_check("ram_slot5", 3'd5, 256'd5);
    bus_read_check("ram_slot3_unwritten", 3'd3, 256'd0);

    // Result register.
    bus_write(3'd7, 256'd203);
    bus_read_check("result_slot7", 3'd7, 256'd203);
    bus_read_check("ram_slot0_after_result", 3'd0, 256'd42);

    // Instruction bulk load while the RAM reads slot 2.
    bus_write(3'd2, INST_WORD);
    @(negedge clk);
    bus_if.address_select = 3'd2;
    bus_if.nEnable        = 1'b0;
    bus_if.ReadWrite      = 1'b1;
    bus_if.load_instrs    = 1'b1;
    #1;
    check_eq("load_bus_slot2", data_bus, INST_WORD);
    @(posedge clk);
    #1;
    go_idle();
    inst_check("inst0",  5'd0,  12'hF0D);
    inst_check("inst1",  5'd1,  12'h301);
    inst_check("inst2",  5'd2,  12'hAAA);
    inst_check("inst3",  5'd3,  12'h00F);
    inst_check("inst5",  5'd5,  12'h200);
    inst_check("inst10", 5'd10, 12'h090);
    inst_check("inst13", 5'd13, 12'hB00);
    inst_check("inst19", 5'd19, 12'h00C);
    inst_check("inst20", 5'd20, 12'h000);
    inst_check("inst21", 5'd21, 12'h000);
    inst_check("inst31", 5'd31, 12'h000);

    // Bus release: an external value must pass through unaltered.
    release_check("release_nen_slot0", 3'd0, 1'b1, 1'b1);
    release_check("release_nen_slot7", 3'd7, 1'b1, 1'b1);
    release_check("release_write_dir", 3'd0, 1'b1, 1'b0);
    bus_read_check("slot0_kept_after_release", 3'd0, 256'd42);

    // Back-to-back write then read.
    bus_write(3'd4, 256'd7);
    bus_read_check("b2b_slot4", 3'd4, 256'd7);
    bus_read_check("b2b_slot5_unchanged", 3'd5, 256'd5);

    // Write and instruction load in the same edge both take effect.
    @(negedge clk);
    bus_if.address_select = 3'd6;
    bus_if.nEnable        = 1'b0;
    bus_if.ReadWrite      = 1'b0;
    bus_if.load_instrs    = 1'b1;
    tb_drv                = SIM_WORD;
    tb_drv_en             = 1'b1;
    @(posedge clk);
    #1;
    go_idle();
    bus_read_check("sim_slot6", 3'd6, SIM_WORD);
    inst_check("sim_inst0",  5'd0,  12'h5A5);
    inst_check("sim_inst1",  5'd1,  12'h0F1);
    inst_check("sim_inst20", 5'd20, 12'h000);

    // Reset mid-operation, with a write and a load attempted during it.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    inst_check("midrst_inst0", 5'd0, 12'h000);
    bus_read_check("midrst_slot0", 3'd0, 256'd0);
    bus_read_check("midrst_slot7", 3'd7, 256'd0);
    release_check("midrst_release", 3'd0, 1'b1, 1'b1);
    @(negedge clk);
    bus_if.address_select = 3'd3;
    bus_if.nEnable        = 1'b0;
    bus_if.ReadWrite      = 1'b0;
    bus_if.load_instrs    = 1'b1;
    tb_drv                = 256'd99;
    tb_drv_en             = 1'b1;
    @(posedge clk);
    #1;
    go_idle();
    @(negedge clk);
    reset_n = 1'b1;
    bus_read_check("postrst_slot3", 3'd3, 256'd0);
    bus_read_check("postrst_slot1", 3'd1, 256'd0);
    bus_read_check("postrst_slot6", 3'd6, 256'd0);
    inst_check("postrst_inst1", 5'd1, 12'h000);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/memory_subsystem.md
# memory_subsystem

Storage complex of the 16-bit RISC matrix engine: an 8-slot, 256-bit shared data bus serving a 7-word main RAM (`memory`) and a result register (`result_reg`), plus a 32-entry, 12-bit instruction store (`instruction_memory`). Instructions are bulk-loaded from one 256-bit bus word. The program counter reads them combinationally.

## Interface
- `DATA_W`, 256: data bus and word width.
- `ADDR_W`, 3: bus address width (8 slots).
- `INST_W`, 12: instruction width.
- `INST_DEPTH`, 32: instruction entries (5-bit address).
- `RESULT_ADDR`, 7: slot owned by `result_reg`; RAM owns slots 0–6.
- `clk` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `dataBus` inout 256: shared tri-state data bus.
- `address_select` in 3: bus slot select.
- `nEnable` in 1: active-low bus access enable.
- `ReadWrite` in 1: 1 = read (block drives bus), 0 = write (block samples bus).
- `load_instrs` in 1: active-high instruction bulk-load strobe.
- `inst_address` in 5: instruction read address (driven by the PC).
- `inst_read` out 12: instruction at `inst_address`.

## Operation
- **Write**: on posedge with `nEnable`=0 and `ReadWrite`=0, the selected slot captures `dataBus`.
  - Slots 0–6 go to the RAM; slot 7 goes to `result_reg`.
  - The non-selected unit is unchanged.
- **Read**: while `nEnable`=0 and `ReadWrite`=1, only the owning unit drives `dataBus` with the stored word; all others drive Z.
- `dataBus` is Z whenever `nEnable`=1 or `ReadWrite`=0. No two units ever drive simultaneously.
- **Instruction load**: on posedge with `load_instrs`=1, the store captures the current `dataBus` value as 21 instructions.
  - Entry i = `dataBus[255-12i -: 12]`, for i = 0..20.
  - `dataBus[3:0]` is ignored.
  - Entries 21–31 are written to 0.
  - The load is independent of `nEnable`/`address_select`. Normally it is issued while the RAM reads a slot, in the same cycle.
- **Instruction read**: `inst_read = inst[inst_address]`, combinational. All 32 addresses are valid; no wrap or error.
- **Simultaneous events**:
  - A bus write and an instruction load in the same cycle: both take effect.
  - The instruction store captures the pre-edge bus value.
  - Write then read of the same slot in consecutive cycles returns the new value.
- **Reset**: asserting `Reset` clears all RAM words, the result register and all instruction entries to 0, immediately and independently of `clk`.
  - Effect during reset: `inst_read`=0, and reads return 0.
  - Reset takes priority over a write or load in the same edge.

## Timing
- Write latency: 1 cycle; data is visible on the bus from the cycle after the write edge.
- Read latency: combinational from `address_select`/`nEnable`/`ReadWrite`; no clock needed.
- Load latency: 1 cycle; `inst_read` reflects the new contents right after the load edge.
- No handshake, no stall, no busy flag; every access completes in one cycle.
- Bus turnaround: the driver releases within the same combinational path as a `nEnable`/`ReadWrite` change.

## Structure
- Shared package `mem_pkg` holds:
  - constants `DATA_W`, `ADDR_W`, `INST_W`, `INST_DEPTH`, `RESULT_ADDR`, `INSTS_PER_WORD`=21;
  - typedefs `word_t` (256 b) and `inst_t` (12 b).
- The top level `memory_subsystem` instantiates three leaf sub-modules: `memory`, `result_reg`, `instruction_memory`. All three share `dataBus`, `clk` and `Reset`.
- Each bus unit contains its own address decode and tri-state driver.

## Test plan
- **Reset**: pulse `Reset` low mid-operation → every read returns 0, `inst_read`=0, `dataBus` Z with `nEnable`=1.
- **RAM write/read**:
  - Write 42 to slot 0, 56 to slot 1, 5 to slot 5.
  - Read slots 0, 1, 5 → bus shows 42, 56, 5.
  - Slot 3 (never written) reads 0.
- **Result register**:
  - Write 203 to slot 7, then read slot 7 → 203.
  - The RAM never drives during this read (no X on the bus).
- **Instruction load**:
  - Write 256'hF0D301AAA00F0002000D0008000200090009000B00060007002200040 00C0004 (no spaces) to slot 2.
  - Read slot 2 with `load_instrs`=1 for one edge.
  - Then `inst_address` 0, 1, 2, 3, 13, 19, 20, 21 → `inst_read` = F0D, 301, AAA, 00F, B00, 00C, 000, 000.
- **Bus release**: `nEnable`=1 or `ReadWrite`=0 → the block drives Z; an external driver value is seen unaltered on `dataBus`.
- **Back-to-back**: write slot 4 = 7, then read slot 4 on the next cycle → 7; slot 5 is unchanged.
